axis_m_s: RTL and testbench
===========================

# axis_m_s

Packet-level AXI-Stream endpoint pair for the NIC simulation bridge. The master half (`axis_m`) streams one packet from a flat byte buffer onto an AXI-Stream master port. The slave half (`axis_s`) accepts AXI-Stream beats into a byte buffer and presents each completed packet for host-side readout. Both halves share one clock and reset and sit between the host-poll logic and the user NIC datapath.

## Interface
- DATAW, 64, stream data width in bits (multiple of 8)
- KEEPW, DATAW/8, bytes per beat
- DTMP, 4096, packet buffer size in bytes (max packet length)

- S_AXI_ACLK  in  1  clock, all logic on rising edge
- S_AXI_ARESETN  in  1  synchronous reset, active-high (1 = reset), despite the legacy name
- i_req  in  8  nonzero = transmit request (sampled only while busy=0)
- i_len  in  32  packet length in bytes
- i_last_keep  in  KEEPW  tkeep for the final beat
- i_data  in  DTMP*8  packet bytes; byte k = i_data[8k+7:8k]; held stable while busy=1
- busy  out  1  master packet in progress
- m_axis_tdata/tkeep/tlast/tvalid  out  DATAW/KEEPW/1/1  master stream
- m_axis_tready  in  1  master backpressure
- s_axis_tdata/tkeep/tlast/tvalid  in  DATAW/KEEPW/1/1  slave stream
- s_axis_tready  out  1  slave ready
- o_pkt_valid  out  1  received packet available
- o_pkt_len  out  13 (clog2(DTMP)+1)  received byte count
- o_pkt_ovf  out  1  received packet exceeded DTMP
- o_pkt_ack  in  1  host consumed received packet
- rd_addr  in  clog2(DTMP)  receive buffer byte address
- rd_data  out  8  combinational read of the receive buffer
- tx_pkt_cnt, rx_pkt_cnt  out  32 each  statistics (see Configuration)

## Operation
- Master FSM: IDLE, SEND.
  - IDLE: if i_req≠0 and i_len≠0, latch len = min(i_len, DTMP), set beats = ceil(len/KEEPW) and beat index 0, go to SEND.
  - IDLE: if i_req≠0 and i_len=0, ignore the request.
- SEND, per beat b: byte j of tdata = buffer byte b*KEEPW+j (little-endian). Bytes beyond len drive 0.
  - tkeep = all ones, except the final beat, which uses i_last_keep.
  - tlast = 1 on the final beat only.
- A handshake (tvalid&tready) advances b. The handshake on the final beat returns to IDLE.
- busy = 1 exactly while in SEND.
- Slave FSM: RECV, HOLD.
  - RECV: tready = 1. On each handshake, write bytes with tkeep[j]=1 to buffer[cnt+popcount-order], then cnt += popcount(tkeep). Writes past DTMP are dropped and set ovf.
  - RECV, handshake with tlast: go to HOLD with o_pkt_valid=1, o_pkt_len=cnt (saturates at DTMP), o_pkt_ovf=ovf.
  - HOLD: tready = 0. When o_pkt_ack=1, clear valid, cnt, and ovf, and return to RECV.
- The receive buffer keeps its contents until it is overwritten. rd_data is valid in HOLD.

## Timing
- Reset values of all outputs are 0 (busy, tvalid, tlast, tkeep, tdata, valid, len, ovf, counters). s_axis_tready is 0 during reset and rises the cycle after reset deasserts.
- Master latency: i_req sampled at edge N makes busy=1 and tvalid=1 with beat 0 after edge N.
- tdata/tkeep/tlast are stable while tvalid=1 and tready=0.
- The final handshake at edge M drops tvalid, tlast, and busy after M. The earliest next request is sampled at M+1, so there is no back-to-back beat between packets.
- Slave: the tlast handshake at edge N makes o_pkt_valid=1 and tready=0 after N. o_pkt_ack at edge P makes tready=1 after P.
- o_pkt_ack while in RECV is ignored.
- Reset mid-packet on either side aborts immediately. No partial tlast is emitted or reported.

## Configuration
- AXIS_M_S_STATS_EN defined:
  - tx_pkt_cnt increments on each master final-beat handshake.
  - rx_pkt_cnt increments on each slave tlast handshake.
  - Both counters wrap at 2^32.
- AXIS_M_S_STATS_EN undefined: counter ports remain present and are tied to 0.

## Test plan
- DATAW=64, i_len=20, i_last_keep=0x0F, tready=1: expect 3 beats; tkeep FF, FF, 0F; tlast on beat 3; busy high for 3 cycles.
- Same packet with tready toggling 1/0 per cycle: expect beats held stable while stalled, 3 handshakes total, identical data.
- i_req=1 with i_len=0: expect no tvalid and busy stays 0. i_len=5000: expect 512 beats (len clamped to 4096).
- Slave receives 2 beats (tkeep FF, then 07, tlast): expect o_pkt_len=11, tready=0 until ack, and rd_data at addr 10 = byte 2 of beat 2.
- Slave receives 513 full beats: expect o_pkt_ovf=1 and o_pkt_len=4096.
- With AXIS_M_S_STATS_EN: 3 TX and 2 RX packets give tx_pkt_cnt=3, rx_pkt_cnt=2. Reset mid-packet clears both counters and all outputs.

Source files
------------

// File: rtl/axis_m_s_if.sv
// axis_m_s_if: AXI-Stream channel bundle with master and slave views.
interface axis_m_s_if #(
    parameter int unsigned DATAW = 64,
    parameter int unsigned KEEPW = DATAW / 8
) ();
    logic [DATAW-1:0] tdata;
    logic [KEEPW-1:0] tkeep;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_m_s.sv
// axis_m_s: packet-level AXI-Stream endpoint pair. The master half streams one
// packet from a flat byte buffer and the slave half collects one packet into a
// byte buffer for host readout. Packet statistics counters are built only when
// AXIS_M_S_STATS_EN is defined; otherwise the counter ports read as zero.
module axis_m_s #(
    parameter int unsigned DATAW = 64,
    parameter int unsigned KEEPW = DATAW / 8,
    parameter int unsigned DTMP  = 4096
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [7:0]              i_req,
    input  logic [31:0]             i_len,
    input  logic [KEEPW-1:0]        i_last_keep,
    input  logic [DTMP*8-1:0]       i_data,
    output logic                    busy,
    axis_m_s_if.master              m_axis,
    axis_m_s_if.slave               s_axis,
    output logic                    o_pkt_valid,
    output logic [$clog2(DTMP):0]   o_pkt_len,
    output logic                    o_pkt_ovf,
    input  logic                    o_pkt_ack,
    input  logic [$clog2(DTMP)-1:0] rd_addr,
    output logic [7:0]              rd_data,
    output logic [31:0]             tx_pkt_cnt,
    output logic [31:0]             rx_pkt_cnt
);
    localparam int unsigned AW   = $clog2(DTMP);
    localparam int unsigned LENW = AW + 1;
    localparam int unsigned KCW  = $clog2(KEEPW + 1);
    localparam int unsigned SUMW = LENW + KCW;
    localparam int unsigned IDXW = LENW + KCW;

    typedef enum logic {M_IDLE = 1'b0, M_SEND = 1'b1} m_state_e;
    typedef enum logic {S_RECV = 1'b0, S_HOLD = 1'b1} s_state_e;

    // ---------------- master half ----------------
    m_state_e          m_state_q, m_state_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   beats_q, beats_d;
    logic [LENW-1:0]   beat_q, beat_d;
    logic              busy_q, busy_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [KEEPW-1:0]  tkeep_q, tkeep_d;
    logic [DATAW-1:0]  tdata_q, tdata_d;
    logic              load_beat;
    logic [IDXW-1:0]   byte_idx;
    logic              m_hs;

    assign m_hs = tvalid_q & m_axis.tready;

    // Master next state; a beat is loaded on request accept and after each non-final handshake.
    always_comb begin
        m_state_d = m_state_q;
        len_d     = len_q;
        beats_d   = beats_q;
        beat_d    = beat_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tkeep_d   = tkeep_q;
        tdata_d   = tdata_q;
        load_beat = 1'b0;
        byte_idx  = '0;
        case (m_state_q)
            M_IDLE: begin
                if (i_req != 8'd0 && i_len != 32'd0) begin
                    len_d     = (i_len > 32'(DTMP)) ? LENW'(DTMP) : LENW'(i_len);
                    beats_d   = LENW'((SUMW'(len_d) + SUMW'(KEEPW - 1)) / SUMW'(KEEPW));
                    beat_d    = '0;
                    m_state_d = M_SEND;
                    load_beat = 1'b1;
                end
            end
            M_SEND: begin
                if (m_hs) begin
                    if (tlast_q) begin
                        m_state_d = M_IDLE;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        tkeep_d   = '0;
                        tdata_d   = '0;
                    end else begin
                        beat_d    = beat_q + LENW'(1);
                        load_beat = 1'b1;
                    end
                end
            end
            default: m_state_d = M_IDLE;
        endcase
        if (load_beat) begin
            tvalid_d = 1'b1;
            tlast_d  = (beat_d == beats_d - LENW'(1));
            tkeep_d  = tlast_d ? i_last_keep : '1;
            for (int j = 0; j < KEEPW; j++) begin
                byte_idx = IDXW'(beat_d) * IDXW'(KEEPW) + IDXW'(j);
                if (byte_idx < IDXW'(len_d)) begin
                    tdata_d[8*j +: 8] = i_data[{AW'(byte_idx), 3'b000} +: 8];
                end else begin
                    tdata_d[8*j +: 8] = 8'h00;
                end
            end
        end
    end

    assign busy_d = (m_state_d == M_SEND);

    // Master state and registered stream outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            m_state_q <= M_IDLE;
            len_q     <= '0;
            beats_q   <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tkeep_q   <= '0;
            tdata_q   <= '0;
        end else begin
            m_state_q <= m_state_d;
            len_q     <= len_d;
            beats_q   <= beats_d;
            beat_q    <= beat_d;
            busy_q    <= busy_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tkeep_q   <= tkeep_d;
            tdata_q   <= tdata_d;
        end
    end

    assign busy          = busy_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tdata  = tdata_q;

    // ---------------- slave half ----------------
    s_state_e          s_state_q, s_state_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              tready_q, tready_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [LENW-1:0]   pkt_len_q, pkt_len_d;
    logic              pkt_ovf_q, pkt_ovf_d;
    logic [KCW-1:0]    off;
    logic [SUMW-1:0]   sum;
    logic [SUMW-1:0]   wr_addr [KEEPW];
    logic [KEEPW-1:0]  wr_en;
    logic              s_hs;
    logic [7:0]        mem_q [DTMP];

    assign s_hs = s_axis.tvalid & tready_q;

    // Slave next state; kept bytes pack densely from the running count, overflow bytes are dropped.
    always_comb begin
        s_state_d   = s_state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        pkt_valid_d = pkt_valid_q;
        pkt_len_d   = pkt_len_q;
        pkt_ovf_d   = pkt_ovf_q;
        off         = '0;
        for (int j = 0; j < KEEPW; j++) begin
            wr_addr[j] = SUMW'(cnt_q) + SUMW'(off);
            wr_en[j]   = s_hs & s_axis.tkeep[j] & (wr_addr[j] < SUMW'(DTMP));
            off        = off + KCW'(s_axis.tkeep[j]);
        end
        sum = SUMW'(cnt_q) + SUMW'(off);
        case (s_state_q)
            S_RECV: begin
                if (s_hs) begin
                    if (sum > SUMW'(DTMP)) begin
                        cnt_d = LENW'(DTMP);
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = LENW'(sum);
                    end
                    if (s_axis.tlast) begin
                        s_state_d   = S_HOLD;
                        pkt_valid_d = 1'b1;
                        pkt_len_d   = cnt_d;
                        pkt_ovf_d   = ovf_d;
                    end
                end
            end
            S_HOLD: begin
                if (o_pkt_ack) begin
                    s_state_d   = S_RECV;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    pkt_valid_d = 1'b0;
                    pkt_len_d   = '0;
                    pkt_ovf_d   = 1'b0;
                end
            end
            default: s_state_d = S_RECV;
        endcase
        tready_d = (s_state_d == S_RECV);
    end

    // Slave state and registered host-side outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            s_state_q   <= S_RECV;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            tready_q    <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_len_q   <= '0;
            pkt_ovf_q   <= 1'b0;
        end else begin
            s_state_q   <= s_state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            tready_q    <= tready_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_len_q   <= pkt_len_d;
            pkt_ovf_q   <= pkt_ovf_d;
        end
    end

    // Receive buffer; contents survive reset and persist until overwritten.
    always_ff @(posedge S_AXI_ACLK) begin
        for (int j = 0; j < KEEPW; j++) begin
            if (wr_en[j]) begin
                mem_q[AW'(wr_addr[j])] <= s_axis.tdata[8*j +: 8];
            end
        end
    end

    assign s_axis.tready = tready_q;
    assign o_pkt_valid   = pkt_valid_q;
    assign o_pkt_len     = pkt_len_q;
    assign o_pkt_ovf     = pkt_ovf_q;
    assign rd_data       = mem_q[rd_addr];

    // ---------------- statistics ----------------
`ifdef AXIS_M_S_STATS_EN
    logic [31:0] tx_cnt_q;
    logic [31:0] rx_cnt_q;

    // Completed-packet counters, wrapping at 2^32.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (m_hs && tlast_q) begin
                tx_cnt_q <= tx_cnt_q + 32'd1;
            end
            if (s_hs && s_axis.tlast) begin
                rx_cnt_q <= rx_cnt_q + 32'd1;
            end
        end
    end

    assign tx_pkt_cnt = tx_cnt_q;
    assign rx_pkt_cnt = rx_cnt_q;
`else
    assign tx_pkt_cnt = '0;
    assign rx_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_axis_m_s.sv
// tb_axis_m_s: table-driven and randomized bench for the axis_m_s endpoint pair.
`timescale 1ns/1ps
module tb_axis_m_s;
    localparam int unsigned DATAW = 64;
    localparam int unsigned KEEPW = 8;
    localparam int unsigned DTMP  = 4096;
    localparam int unsigned AW    = 12;

    typedef struct {
        int unsigned len;
        logic [7:0]  lk;
        int          mode;
        int unsigned exp_beats;
    } tx_vec_t;

    typedef struct {
        int unsigned nbeats;
        logic [7:0]  k_body;
        logic [7:0]  k_last;
        int unsigned exp_len;
        bit          exp_ovf;
        bit          gaps;
    } rx_vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        i_req;
    logic [31:0]       i_len;
    logic [KEEPW-1:0]  i_last_keep;
    logic [DTMP*8-1:0] i_data;
    logic              busy;
    logic              o_pkt_valid;
    logic [AW:0]       o_pkt_len;
    logic              o_pkt_ovf;
    logic              o_pkt_ack;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_data;
    logic [31:0]       tx_pkt_cnt;
    logic [31:0]       rx_pkt_cnt;

    axis_m_s_if #(.DATAW(DATAW), .KEEPW(KEEPW)) m_if ();
    axis_m_s_if #(.DATAW(DATAW), .KEEPW(KEEPW)) s_if ();

    axis_m_s #(.DATAW(DATAW), .KEEPW(KEEPW), .DTMP(DTMP)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst),
        .i_req         (i_req),
        .i_len         (i_len),
        .i_last_keep   (i_last_keep),
        .i_data        (i_data),
        .busy          (busy),
        .m_axis        (m_if),
        .s_axis        (s_if),
        .o_pkt_valid   (o_pkt_valid),
        .o_pkt_len     (o_pkt_len),
        .o_pkt_ovf     (o_pkt_ovf),
        .o_pkt_ack     (o_pkt_ack),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .tx_pkt_cnt    (tx_pkt_cnt),
        .rx_pkt_cnt    (rx_pkt_cnt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned tx_done  = 0;
    int unsigned rx_done  = 0;
    logic [7:0]  txbuf [DTMP];
    logic [7:0]  rx_keeps [$];
    logic [7:0]  rx_exp [$];
    tx_vec_t     tx_tab [8];
    rx_vec_t     rx_tab [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_tx();
        for (int k = 0; k < DTMP; k++) begin
            txbuf[k] = 8'($urandom);
            i_data[8*k +: 8] = txbuf[k];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_tvalid"}, 64'(m_if.tvalid), 64'd0);
        chk({tag, "_tlast"},  64'(m_if.tlast), 64'd0);
        chk({tag, "_tkeep"},  64'(m_if.tkeep), 64'd0);
        chk({tag, "_tdata"},  m_if.tdata, 64'd0);
        chk({tag, "_sready"}, 64'(s_if.tready), 64'd0);
        chk({tag, "_pvalid"}, 64'(o_pkt_valid), 64'd0);
        chk({tag, "_plen"},   64'(o_pkt_len), 64'd0);
        chk({tag, "_povf"},   64'(o_pkt_ovf), 64'd0);
        chk({tag, "_txcnt"},  64'(tx_pkt_cnt), 64'd0);
        chk({tag, "_rxcnt"},  64'(rx_pkt_cnt), 64'd0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef AXIS_M_S_STATS_EN
        chk({tag, "_txcnt"}, 64'(tx_pkt_cnt), 64'(tx_done));
        chk({tag, "_rxcnt"}, 64'(rx_pkt_cnt), 64'(rx_done));
`else
        chk({tag, "_txcnt"}, 64'(tx_pkt_cnt), 64'd0);
        chk({tag, "_rxcnt"}, 64'(rx_pkt_cnt), 64'd0);
`endif
    endtask

    // One master packet; mode 0 = always ready, 1 = toggling, 2 = random.
    task automatic run_tx(input int unsigned len, input logic [7:0] lk, input int mode,
                          input int unsigned exp_beats);
        int unsigned L, eb, nb, bcyc, cyc;
        logic [63:0] ed, pd;
        logic [7:0]  pk;
        logic        pl;
        bit          stalled, stable_ok, busy_ok, tr;
        L  = (len > DTMP) ? DTMP : len;
        eb = (L + KEEPW - 1) / KEEPW;
        fill_tx();
        @(negedge clk);
        i_req        = 8'($urandom_range(1, 255));
        i_len        = len;
        i_last_keep  = lk;
        m_if.tready  = (mode == 0);
        @(negedge clk);
        i_req = 8'd0;
        chk($sformatf("tx%0d_start_valid", len), 64'(m_if.tvalid), 64'(L != 0));
        chk($sformatf("tx%0d_start_busy", len), 64'(busy), 64'(L != 0));
        nb = 0; bcyc = 0; cyc = 0;
        stalled = 1'b0; stable_ok = 1'b1; busy_ok = 1'b1;
        pd = '0; pk = '0; pl = 1'b0;
        while (m_if.tvalid === 1'b1 && cyc < 20000) begin
            if (busy === 1'b1) bcyc++;
            else busy_ok = 1'b0;
            if (stalled && (m_if.tdata !== pd || m_if.tkeep !== pk || m_if.tlast !== pl))
                stable_ok = 1'b0;
            case (mode)
                0:       tr = 1'b1;
                1:       tr = ((cyc % 2) == 0);
                default: tr = ($urandom_range(0, 1) == 1);
            endcase
            m_if.tready = tr;
            if (tr) begin
                ed = '0;
                for (int j = 0; j < KEEPW; j++)
                    if (nb * KEEPW + j < L) ed[8*j +: 8] = txbuf[nb * KEEPW + j];
                chk($sformatf("tx%0d_data_b%0d", len, nb), m_if.tdata, ed);
                chk($sformatf("tx%0d_keep_b%0d", len, nb), 64'(m_if.tkeep),
                    64'((nb == eb - 1) ? lk : 8'hFF));
                chk($sformatf("tx%0d_last_b%0d", len, nb), 64'(m_if.tlast), 64'(nb == eb - 1));
                nb++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pd = m_if.tdata; pk = m_if.tkeep; pl = m_if.tlast;
            end
            @(negedge clk);
            cyc++;
        end
        m_if.tready = 1'b0;
        chk($sformatf("tx%0d_beats", len), 64'(nb), 64'(exp_beats));
        chk($sformatf("tx%0d_busy_track", len), 64'(busy_ok), 64'd1);
        chk($sformatf("tx%0d_stall_stable", len), 64'(stable_ok), 64'd1);
        if (mode == 0) chk($sformatf("tx%0d_busy_cycles", len), 64'(bcyc), 64'(exp_beats));
        if (L == 0) repeat (3) @(negedge clk);
        chk($sformatf("tx%0d_end_busy", len), 64'(busy), 64'd0);
        chk($sformatf("tx%0d_end_valid", len), 64'(m_if.tvalid), 64'd0);
        if (L != 0) tx_done++;
    endtask

    // One slave packet from rx_keeps; readback and ack sequence included.
    task automatic run_rx(input int unsigned exp_len, input bit exp_ovf, input bit gaps);
        int unsigned nb, i, cyc, a;
        logic [63:0] d;
        bit          have;
        rx_exp.delete();
        nb = rx_keeps.size(); i = 0; cyc = 0; have = 1'b0; d = '0;
        while (i < nb && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!have) begin
                d = {$urandom, $urandom};
                have = 1'b1;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_if.tvalid = 1'b0;
            end else begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = d;
                s_if.tkeep  = rx_keeps[i];
                s_if.tlast  = (i == nb - 1);
                if (s_if.tready === 1'b1) begin
                    for (int j = 0; j < KEEPW; j++)
                        if (rx_keeps[i][j]) rx_exp.push_back(d[8*j +: 8]);
                    i++;
                    have = 1'b0;
                end
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk($sformatf("rx%0d_beats_sent", exp_len), 64'(i), 64'(nb));
        chk($sformatf("rx%0d_valid", exp_len), 64'(o_pkt_valid), 64'd1);
        chk($sformatf("rx%0d_ready_low", exp_len), 64'(s_if.tready), 64'd0);
        chk($sformatf("rx%0d_len", exp_len), 64'(o_pkt_len), 64'(exp_len));
        chk($sformatf("rx%0d_ovf", exp_len), 64'(o_pkt_ovf), 64'(exp_ovf));
        repeat (2) @(negedge clk);
        chk($sformatf("rx%0d_hold_ready", exp_len), 64'(s_if.tready), 64'd0);
        chk($sformatf("rx%0d_hold_valid", exp_len), 64'(o_pkt_valid), 64'd1);
        if (exp_len <= 64) begin
            for (int unsigned k = 0; k < exp_len; k++) begin
                rd_addr = AW'(k);
                #1;
                chk($sformatf("rx%0d_rd_%0d", exp_len, k), 64'(rd_data), 64'(rx_exp[k]));
            end
        end else begin
            for (int k = 0; k < 16; k++) begin
                a = (k == 0) ? exp_len - 1 : $urandom_range(0, exp_len - 1);
                rd_addr = AW'(a);
                #1;
                chk($sformatf("rx%0d_rd_%0d", exp_len, a), 64'(rd_data), 64'(rx_exp[a]));
            end
        end
        @(negedge clk);
        o_pkt_ack = 1'b1;
        @(negedge clk);
        o_pkt_ack = 1'b0;
        chk($sformatf("rx%0d_ack_ready", exp_len), 64'(s_if.tready), 64'd1);
        chk($sformatf("rx%0d_ack_valid", exp_len), 64'(o_pkt_valid), 64'd0);
        chk($sformatf("rx%0d_ack_ovf", exp_len), 64'(o_pkt_ovf), 64'd0);
        rx_done++;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned tot, len;
        logic [7:0]  k;

        tx_tab[0] = '{20,   8'h0F, 0, 3};
        tx_tab[1] = '{20,   8'h0F, 1, 3};
        tx_tab[2] = '{0,    8'hFF, 0, 0};
        tx_tab[3] = '{5000, 8'hFF, 0, 512};
        tx_tab[4] = '{8,    8'hFF, 0, 1};
        tx_tab[5] = '{1,    8'h01, 1, 1};
        tx_tab[6] = '{9,    8'h01, 2, 2};
        tx_tab[7] = '{4096, 8'hFF, 2, 512};

        rx_tab[0] = '{2,   8'hFF, 8'h07, 11,   1'b0, 1'b0};
        rx_tab[1] = '{513, 8'hFF, 8'hFF, 4096, 1'b1, 1'b0};
        rx_tab[2] = '{1,   8'hFF, 8'hA5, 4,    1'b0, 1'b0};
        rx_tab[3] = '{3,   8'h0F, 8'hF0, 12,   1'b0, 1'b1};
        rx_tab[4] = '{512, 8'hFF, 8'hFF, 4096, 1'b0, 1'b1};
        rx_tab[5] = '{2,   8'h00, 8'h01, 1,    1'b0, 1'b1};

        rst = 1'b1;
        i_req = '0; i_len = '0; i_last_keep = '0; i_data = '0;
        o_pkt_ack = 1'b0; rd_addr = '0;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_sready", 64'(s_if.tready), 64'd1);

        // Ack while receiving must be ignored.
        o_pkt_ack = 1'b1;
        @(negedge clk);
        o_pkt_ack = 1'b0;
        chk("recv_ack_ready", 64'(s_if.tready), 64'd1);
        chk("recv_ack_valid", 64'(o_pkt_valid), 64'd0);

        foreach (tx_tab[t]) run_tx(tx_tab[t].len, tx_tab[t].lk, tx_tab[t].mode, tx_tab[t].exp_beats);
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 100);
            run_tx(len, 8'($urandom_range(1, 255)), 2, (len + KEEPW - 1) / KEEPW);
        end

        foreach (rx_tab[t]) begin
            rx_keeps.delete();
            for (int unsigned b = 0; b < rx_tab[t].nbeats; b++)
                rx_keeps.push_back((b == rx_tab[t].nbeats - 1) ? rx_tab[t].k_last : rx_tab[t].k_body);
            run_rx(rx_tab[t].exp_len, rx_tab[t].exp_ovf, rx_tab[t].gaps);
        end
        for (int r = 0; r < 6; r++) begin
            rx_keeps.delete();
            tot = 0;
            for (int b = 0; b < int'($urandom_range(1, 20)); b++) begin
                k = 8'($urandom);
                rx_keeps.push_back(k);
                tot += $countones(k);
            end
            run_rx(tot, 1'b0, 1'b1);
        end
        chk_stats("stats");

        // Reset in the middle of a TX packet and an RX packet.
        fill_tx();
        @(negedge clk);
        i_req = 8'd1; i_len = 32'd100; i_last_keep = 8'hFF; m_if.tready = 1'b1;
        s_if.tvalid = 1'b1; s_if.tdata = {$urandom, $urandom}; s_if.tkeep = 8'hFF; s_if.tlast = 1'b0;
        @(negedge clk);
        i_req = 8'd0; s_if.tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        m_if.tready = 1'b0;
        @(negedge clk);
        chk("midrst_after_sready", 64'(s_if.tready), 64'd1);
        chk("midrst_after_valid", 64'(m_if.tvalid), 64'd0);
        chk("midrst_after_pvalid", 64'(o_pkt_valid), 64'd0);
        tx_done = 0;
        rx_done = 0;
        run_tx(20, 8'h0F, 0, 3);
        rx_keeps.delete();
        rx_keeps.push_back(8'h0F);
        run_rx(4, 1'b0, 1'b0);
        chk_stats("stats_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
